ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_sync.sv | 31 +++
 rtl/ps2_host_tx.sv | 192 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmitter and the mouse receiver:
// transmitter state encoding, frame length, command bytes and frame packing.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      INHIBIT  = 3'd1,
      START    = 3'd2,
      SHIFT    = 3'd3,
      ACK      = 3'd4,
      WAITIDLE = 3'd5
   } ps2_state_t;

   // Data-phase bits clocked out after the start bit: d0..d7, parity, stop.
   localparam int PS2_FRAME_BITS = 10;

   localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

   // {stop, odd parity, data} with d0 at the LSB, ready to shift out right.
   function automatic logic [PS2_FRAME_BITS-1:0] ps2_tx_frame(input logic [7:0] d);
      return {1'b1, ~^d, d};
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 pin plus a previous-level register that
// yields a single-cycle falling-edge strobe.
module ps2_line_sync (
   input  logic clk_sys,
   input  logic reset,
   input  logic i_pin,
   output logic o_level,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Reset to the idle (released, pulled-up) level so reset exit never fakes an edge.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= i_pin;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-collector pull-low enables.
// Optional watchdog on device clock edges: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYC = 9600,
   parameter int TIMEOUT_CYC = 1440000
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_req,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic       rx_inhibit,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output ps2_state_t o_dbg_state
);

   localparam int INH_W = $clog2(INHIBIT_CYC + 1);

   ps2_state_t                r_state;
   ps2_state_t                w_next;
   logic [PS2_FRAME_BITS-1:0] r_shreg;
   logic [3:0]                r_bit_cnt;
   logic [INH_W-1:0]          r_inh_cnt;
   logic                      r_data_oe;
   logic                      r_ok;
   logic                      r_done;
   logic                      r_error;

   logic w_clk_lvl;
   logic w_clk_fall;
   logic w_data_lvl;
   logic w_unused_data_fall;
   logic w_inh_last;
   logic w_last_bit;
   logic w_bus_idle;
   logic w_timeout;
   logic w_clk_oe;
   logic w_data_oe;

   ps2_line_sync u_clk_sync (
      .clk_sys (clk_sys),
      .reset   (reset),
      .i_pin   (ps2_clk_in),
      .o_level (w_clk_lvl),
      .o_fall  (w_clk_fall)
   );

   ps2_line_sync u_data_sync (
      .clk_sys (clk_sys),
      .reset   (reset),
      .i_pin   (ps2_data_in),
      .o_level (w_data_lvl),
      .o_fall  (w_unused_data_fall)
   );

   assign w_inh_last = (r_inh_cnt == INH_W'(INHIBIT_CYC - 1));
   assign w_last_bit = (r_bit_cnt == 4'(PS2_FRAME_BITS - 1));
   assign w_bus_idle = w_clk_lvl & w_data_lvl;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] r_wdog;
   logic            w_wd_active;

   assign w_wd_active = (r_state == START) || (r_state == SHIFT) ||
                        (r_state == ACK)   || (r_state == WAITIDLE);

   // Restarts on every device clock fall, so it bounds the gap between edges.
   always_ff @(posedge clk_sys) begin
      if (reset || !w_wd_active || w_clk_fall) begin
         r_wdog <= '0;
      end else begin
         r_wdog <= r_wdog + 1'b1;
      end
   end

   assign w_timeout = w_wd_active && !w_clk_fall && (r_wdog == WD_W'(TIMEOUT_CYC - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYC == 0);
   assign w_timeout        = 1'b0;
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_clk_oe  = 1'b0;
      w_data_oe = 1'b0;
      case (r_state)
         IDLE: begin
            if (tx_req) w_next = INHIBIT;
         end
         INHIBIT: begin
            w_clk_oe = 1'b1;
            if (w_inh_last) w_next = START;
         end
         START: begin
            w_clk_oe  = 1'b1;
            w_data_oe = 1'b1;
            w_next    = SHIFT;
         end
         SHIFT: begin
            w_data_oe = r_data_oe;
            if (w_clk_fall && w_last_bit) w_next = ACK;
         end
         ACK: begin
            if (w_clk_fall) w_next = WAITIDLE;
         end
         WAITIDLE: begin
            if (w_bus_idle) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      if (w_timeout) begin
         w_next    = IDLE;
         w_clk_oe  = 1'b0;
         w_data_oe = 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_inh_cnt <= '0;
         r_data_oe <= 1'b0;
         r_ok      <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            IDLE: begin
               if (tx_req) begin
                  r_shreg   <= ps2_tx_frame(tx_data);
                  r_bit_cnt <= '0;
                  r_inh_cnt <= '0;
               end
            end
            INHIBIT: r_inh_cnt <= r_inh_cnt + 1'b1;
            // Start bit stays on the line until the device's first clock fall.
            START:   r_data_oe <= 1'b1;
            SHIFT: begin
               if (w_clk_fall) begin
                  r_data_oe <= ~r_shreg[0];
                  r_shreg   <= {1'b0, r_shreg[PS2_FRAME_BITS-1:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            ACK: begin
               if (w_clk_fall) r_ok <= ~w_data_lvl;
            end
            WAITIDLE: begin
               if (w_bus_idle) begin
                  r_done  <= r_ok;
                  r_error <= ~r_ok;
               end
            end
            default: ;
         endcase
         if (w_timeout) begin
            r_done  <= 1'b0;
            r_error <= 1'b1;
         end
      end
   end

   assign busy        = (r_state != IDLE);
   assign rx_inhibit  = busy;
   assign done        = r_done;
   assign error       = r_error;
   assign ps2_clk_oe  = w_clk_oe;
   assign ps2_data_oe = w_data_oe;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of
// the host and a frame scoreboard holds hand-computed {stop, parity, data} words.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH = 20;
   localparam int TMO = 200;
   localparam int H   = 30;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       busy, done, error, rx_inhibit;
   logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
   ps2_state_t dbg_state;

   logic dev_clk;
   logic dev_data;

   int n_checks = 0;
   int n_bad    = 0;
   logic [9:0] exp_q[$];

   // Wired-AND open-collector lines with pull-ups.
   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk);
   assign ps2_data_in = ~(ps2_data_oe | dev_data);

   ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .tx_data     (tx_data),
      .tx_req      (tx_req),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .rx_inhibit  (rx_inhibit),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .o_dbg_state (dbg_state)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "bench time limit");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic start_tx(input logic [7:0] d);
      @(negedge clk_sys);
      tx_data = d;
      tx_req  = 1'b1;
      @(negedge clk_sys);
      tx_req  = 1'b0;
      check_eq("req_busy", busy, 1);
      check_eq("req_clk_oe", ps2_clk_oe, 1);
      check_eq("req_rx_inhibit", rx_inhibit, 1);
   endtask

   // Entered at the first busy cycle; leaves at the first cycle with the clock released.
   task automatic inhibit_phase();
      int   n    = 0;
      int   dhi  = 0;
      logic last = 1'b0;
      while (ps2_clk_oe && n < INH + 50) begin
         n++;
         if (ps2_data_oe) dhi++;
         last = ps2_data_oe;
         @(negedge clk_sys);
      end
      check_eq("inh_clk_cycles", n, INH + 1);
      check_eq("inh_data_cycles", dhi, 1);
      check_eq("inh_data_last", last, 1);
      check_eq("start_bit_held", ps2_data_oe, 1);
   endtask

   task automatic dev_frame(input int npulses, input logic ack, input logic poke);
      logic [9:0] got = '0;
      logic [9:0] exp;
      repeat (H) @(negedge clk_sys);
      for (int p = 1; p <= npulses; p++) begin
         if (p == 11 && ack) dev_data = 1'b1;
         repeat (H / 2) @(negedge clk_sys);
         dev_clk = 1'b1;
         repeat (H) @(negedge clk_sys);
         if (p <= 10) got[p-1] = ps2_data_in;
         dev_clk = 1'b0;
         if (p == 11) begin
            dev_data = 1'b0;
         end else begin
            if (poke && p == 3) begin
               tx_data = 8'h00;
               tx_req  = 1'b1;
               @(negedge clk_sys);
               tx_req  = 1'b0;
            end
            repeat (H / 2) @(negedge clk_sys);
         end
      end
      if (npulses >= 10) begin
         if (exp_q.size() == 0) begin
            check_eq("frame_queue_empty", 1, 0);
         end else begin
            exp = exp_q.pop_front();
            check_eq("frame_bits", got, exp);
         end
      end
   endtask

   task automatic wait_end(input logic req_on_done, output int nd, output int ne, output int nb);
      nd = 0;
      ne = 0;
      nb = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_sys);
         if (done) nd++;
         if (error) ne++;
         if (done && error) nb++;
         if (req_on_done && (done || error)) begin
            check_eq("busy_at_pulse", busy, 0);
            tx_data = PS2_CMD_ENABLE;
            tx_req  = 1'b1;
            @(negedge clk_sys);
            tx_req  = 1'b0;
            check_eq("req_on_pulse_accepted", busy, 1);
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk_sys);
      reset = 1'b1;
      @(negedge clk_sys);
      reset = 1'b0;
   endtask

   initial begin
      int nd, ne, nb;
      reset    = 1'b1;
      tx_req   = 1'b0;
      tx_data  = 8'h00;
      dev_clk  = 1'b0;
      dev_data = 1'b0;
      repeat (3) @(negedge clk_sys);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_error", error, 0);
      check_eq("rst_rx_inhibit", rx_inhibit, 0);
      check_eq("rst_clk_oe", ps2_clk_oe, 0);
      check_eq("rst_data_oe", ps2_data_oe, 0);
      check_eq("rst_state", dbg_state, IDLE);
      reset = 1'b0;

      // F4 with ACK: bits 0,0,1,0,1,1,1,1 then parity 0, stop 1.
      exp_q.push_back(10'h2F4);
      start_tx(8'hF4);
      inhibit_phase();
      dev_frame(11, 1'b1, 1'b0);
      wait_end(1'b0, nd, ne, nb);
      check_eq("f4_done", nd, 1);
      check_eq("f4_error", ne, 0);
      check_eq("f4_both", nb, 0);
      check_eq("f4_busy_end", busy, 0);

      // FF with ACK: parity bit 1.
      exp_q.push_back(10'h3FF);
      start_tx(8'hFF);
      inhibit_phase();
      dev_frame(11, 1'b1, 1'b0);
      wait_end(1'b0, nd, ne, nb);
      check_eq("ff_done", nd, 1);
      check_eq("ff_error", ne, 0);

      // 55 with NACK: parity 1, error pulse, busy released.
      exp_q.push_back(10'h355);
      start_tx(8'h55);
      inhibit_phase();
      dev_frame(11, 1'b0, 1'b0);
      wait_end(1'b0, nd, ne, nb);
      check_eq("nack_done", nd, 0);
      check_eq("nack_error", ne, 1);
      check_eq("nack_both", nb, 0);
      check_eq("nack_busy_end", busy, 0);

      // Request during SHIFT is dropped: frame stays F4, no second inhibit afterwards.
      exp_q.push_back(10'h2F4);
      start_tx(8'hF4);
      inhibit_phase();
      dev_frame(11, 1'b1, 1'b1);
      wait_end(1'b0, nd, ne, nb);
      check_eq("poke_done", nd, 1);
      repeat (5) @(negedge clk_sys);
      check_eq("poke_no_refire_busy", busy, 0);
      check_eq("poke_no_refire_clk", ps2_clk_oe, 0);

      // Reset after the 5th device clock.
      start_tx(8'hA3);
      inhibit_phase();
      dev_frame(5, 1'b1, 1'b0);
      @(negedge clk_sys);
      reset = 1'b1;
      @(negedge clk_sys);
      reset = 1'b0;
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_clk_oe", ps2_clk_oe, 0);
      check_eq("midrst_data_oe", ps2_data_oe, 0);
      check_eq("midrst_done", done, 0);
      check_eq("midrst_error", error, 0);

      // New request in the same cycle as the done pulse is taken.
      exp_q.push_back(10'h3FF);
      start_tx(PS2_CMD_RESET);
      inhibit_phase();
      dev_frame(11, 1'b1, 1'b0);
      wait_end(1'b1, nd, ne, nb);
      check_eq("b2b_done", nd, 1);
      do_reset();
      check_eq("b2b_cleared", busy, 0);

`ifdef PS2_TX_TIMEOUT_EN
      // Absent device: error TMO cycles after START, lines released.
      begin
         int t = 1;
         start_tx(8'hF4);
         inhibit_phase();
         while (!error && t < TMO + 50) begin
            @(negedge clk_sys);
            t++;
         end
         check_eq("tmo_cycles", t, TMO);
         check_eq("tmo_error", error, 1);
         check_eq("tmo_done", done, 0);
         check_eq("tmo_clk_oe", ps2_clk_oe, 0);
         check_eq("tmo_data_oe", ps2_data_oe, 0);
         @(negedge clk_sys);
         check_eq("tmo_busy_after", busy, 0);
      end
`endif

      check_eq("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
